truth_table_sweeper: RTL and testbench

- Sequencer that drives one shared combinational logic-function unit (the guia-04 style `fxy` blocks) through every input combination.
- Waits a programmable settle time per vector, then samples the function output and builds the measured truth table.
- Compares each sample against an expected table and reports pass/fail, mismatch count and first failing index.
- Replaces hand-written `#1` stimulus sequences with a reusable clocked checker that sits between a test harness and the function under evaluation.

---
 rtl/truth_table_sweeper.sv | 140 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Clocked sweeper: walks a combinational function unit through every input vector,
// samples its output after a settle delay and compares the measured truth table.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [(1<<N_IN)-1:0]    expected,
  output logic [N_IN-1:0]         f_in,
  input  logic                    f_out,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<N_IN)-1:0]    table_out,
  output logic                    pass,
  output logic [N_IN:0]           mismatch_cnt,
  output logic [N_IN-1:0]         first_bad,
  output logic                    bad_valid
);

  localparam int              NVEC     = 1 << N_IN;
  localparam logic [7:0]      SETTLE_C = 8'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [7:0]        settleCnt_q, settleCnt_d;
  logic [NVEC-1:0]   expCopy_q, expCopy_d;
  logic [NVEC-1:0]   table_q, table_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     misCnt_q, misCnt_d;
  logic [N_IN-1:0]   firstBad_q, firstBad_d;
  logic              badValid_q, badValid_d;
  logic              sampleMismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      settleCnt_q <= '0;
      expCopy_q   <= '0;
      table_q     <= '0;
      pass_q      <= 1'b0;
      misCnt_q    <= '0;
      firstBad_q  <= '0;
      badValid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settleCnt_q <= settleCnt_d;
      expCopy_q   <= expCopy_d;
      table_q     <= table_d;
      pass_q      <= pass_d;
      misCnt_q    <= misCnt_d;
      firstBad_q  <= firstBad_d;
      badValid_q  <= badValid_d;
    end
  end

  // The vector index doubles as f_in, so it only moves on the SAMPLE->WAIT edge.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    settleCnt_d    = settleCnt_q;
    expCopy_d      = expCopy_q;
    table_d        = table_q;
    pass_d         = pass_q;
    misCnt_d       = misCnt_q;
    firstBad_d     = firstBad_q;
    badValid_d     = badValid_q;
    sampleMismatch = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          expCopy_d   = expected;
          table_d     = '0;
          misCnt_d    = '0;
          firstBad_d  = '0;
          badValid_d  = 1'b0;
          pass_d      = 1'b0;
          idx_d       = '0;
          settleCnt_d = SETTLE_C;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (settleCnt_q == 8'd0) begin
          state_d = S_SAMPLE;
        end else begin
          settleCnt_d = settleCnt_q - 8'd1;
        end
      end
      S_SAMPLE: begin
        table_d[idx_q] = f_out;
        sampleMismatch = (f_out != expCopy_q[idx_q]);
        if (sampleMismatch) begin
          misCnt_d = misCnt_q + (N_IN+1)'(1);
          if (!badValid_q) begin
            firstBad_d = idx_q;
            badValid_d = 1'b1;
          end
        end
        // Last-vector test comes before the increment so idx never wraps.
        if (idx_q == LAST_IDX) begin
          pass_d  = (misCnt_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d       = idx_q + N_IN'(1);
          settleCnt_d = SETTLE_C;
          state_d     = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign f_in         = idx_q;
  assign busy         = (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign done         = (state_q == S_DONE);
  assign table_out    = table_q;
  assign pass         = pass_q;
  assign mismatch_cnt = misCnt_q;
  assign first_bad    = firstBad_q;
  assign bad_valid    = badValid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table-driven sweeps scored through a result queue,
// plus hand-written sequences for timing, start-while-busy, reset and back-to-back.
module tb_truth_table_sweeper;

  localparam int N_IN = 3;
  localparam int NVEC = 8;
  localparam int SWEEP_EDGES = NVEC * (1 + 2);

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [NVEC-1:0] expected;
  logic [N_IN-1:0] fIn;
  logic            fOut;
  logic            busy, done, pass, badValid;
  logic [NVEC-1:0] tableOut;
  logic [N_IN:0]   misCnt;
  logic [N_IN-1:0] firstBad;

  logic            start0;
  logic [NVEC-1:0] expected0;
  logic [N_IN-1:0] fIn0;
  logic            fOut0;
  logic            busy0, done0, pass0, badValid0;
  logic [NVEC-1:0] tableOut0;
  logic [N_IN:0]   misCnt0;
  logic [N_IN-1:0] firstBad0;

  logic            fSel;
  int              compared = 0;
  int              mismatched = 0;
  int              cyc = 0;

  typedef struct {
    logic [NVEC-1:0] tbl;
    logic            pass;
    logic [N_IN:0]   cnt;
    logic [N_IN-1:0] first;
    logic            bad;
    int              startCyc;
  } result_t;

  typedef struct {
    logic            sel;
    logic [NVEC-1:0] expIn;
    logic [NVEC-1:0] tbl;
    logic            pass;
    logic [N_IN:0]   cnt;
    logic [N_IN-1:0] first;
    logic            bad;
  } vector_t;

  result_t sbQ[$];
  result_t monRes;
  vector_t vecs[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Function units under evaluation: sel=0 is fxy, sel=1 is 3-input parity.
  function automatic logic unitFn(input logic sel, input logic [N_IN-1:0] v);
    if (sel) return ^v;
    return ~(v[2] & v[1]) | ~(v[2] | v[1]);
  endfunction

  assign fOut  = unitFn(fSel, fIn);
  assign fOut0 = unitFn(1'b0, fIn0);

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .expected(expected),
    .f_in(fIn), .f_out(fOut), .busy(busy), .done(done),
    .table_out(tableOut), .pass(pass), .mismatch_cnt(misCnt),
    .first_bad(firstBad), .bad_valid(badValid)
  );

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .expected(expected0),
    .f_in(fIn0), .f_out(fOut0), .busy(busy0), .done(done0),
    .table_out(tableOut0), .pass(pass0), .mismatch_cnt(misCnt0),
    .first_bad(firstBad0), .bad_valid(badValid0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending sweep.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got done with empty queue, required no done");
      end else begin
        monRes = sbQ.pop_front();
        checkOutput("done_latency", cyc - monRes.startCyc, SWEEP_EDGES);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("table_out", tableOut, monRes.tbl);
        checkOutput("pass", pass, monRes.pass);
        checkOutput("mismatch_cnt", misCnt, monRes.cnt);
        checkOutput("first_bad", firstBad, monRes.first);
        checkOutput("bad_valid", badValid, monRes.bad);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_f_in"}, fIn, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_table"}, tableOut, 0);
    checkOutput({tag, "_pass"}, pass, 0);
    checkOutput({tag, "_cnt"}, misCnt, 0);
    checkOutput({tag, "_first"}, firstBad, 0);
    checkOutput({tag, "_bad"}, badValid, 0);
  endtask

  // Returns on the negedge just after the accepting edge.
  task automatic applyStimulus(input vector_t v, input bit push);
    result_t r;
    @(negedge clk);
    fSel     = v.sel;
    expected = v.expIn;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    r.tbl = v.tbl; r.pass = v.pass; r.cnt = v.cnt;
    r.first = v.first; r.bad = v.bad; r.startCyc = cyc;
    if (push) sbQ.push_back(r);
  endtask

  task automatic waitDone(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!done) checkOutput("done_timeout", done, 1);
  endtask

  initial begin
    int doneCount;
    int d1;
    result_t r;

    vecs[0] = '{1'b0, 8'h3F, 8'h3F, 1'b1, 4'd0, 3'd0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h3F, 1'b0, 4'd2, 3'd6, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 8'h3F, 1'b0, 4'd6, 3'd0, 1'b1};
    vecs[3] = '{1'b0, 8'h3E, 8'h3F, 1'b0, 4'd1, 3'd0, 1'b1};
    vecs[4] = '{1'b0, 8'h7F, 8'h3F, 1'b0, 4'd1, 3'd6, 1'b1};
    vecs[5] = '{1'b0, 8'hC0, 8'h3F, 1'b0, 4'd8, 3'd0, 1'b1};
    vecs[6] = '{1'b1, 8'h96, 8'h96, 1'b1, 4'd0, 3'd0, 1'b0};
    vecs[7] = '{1'b1, 8'h16, 8'h96, 1'b0, 4'd1, 3'd7, 1'b1};
    vecs[8] = '{1'b1, 8'h69, 8'h96, 1'b0, 4'd8, 3'd0, 1'b1};
    vecs[9] = '{1'b0, 8'h2F, 8'h3F, 1'b0, 4'd1, 3'd4, 1'b1};

    reset = 1'b1; start = 1'b0; start0 = 1'b0;
    expected = '0; expected0 = 8'h3F; fSel = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], 1'b1);
      waitDone(100);
      @(negedge clk);
      checkOutput("hold_table", tableOut, vecs[i].tbl);
      checkOutput("hold_f_in", fIn, 3'b111);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
    end

    // SETTLE=0: each vector held exactly two cycles, done 16 edges after start.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      checkOutput("order_f_in", fIn0, j / 2);
      checkOutput("order_busy", busy0, 1);
      @(negedge clk);
    end
    checkOutput("order_done", done0, 1);
    checkOutput("order_busy_end", busy0, 0);
    checkOutput("order_table", tableOut0, 8'h3F);

    // Second start pulse at edge 5 must be ignored.
    applyStimulus(vecs[0], 1'b1);
    doneCount = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = (k == 4);
      if (done) doneCount++;
    end
    checkOutput("busy_start_one_done", doneCount, 1);

    // Reset asserted at edge 10 of a sweep.
    applyStimulus(vecs[1], 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkAllZero("midreset");
    @(negedge clk);
    checkOutput("midreset_idle", busy, 0);
    applyStimulus(vecs[0], 1'b1);
    waitDone(100);
    @(negedge clk);

    // Start held high through two sweeps.
    fSel = 1'b0;
    expected = 8'h00;
    start = 1'b1;
    @(negedge clk);
    r.tbl = 8'h3F; r.pass = 1'b0; r.cnt = 4'd6; r.first = 3'd0; r.bad = 1'b1;
    r.startCyc = cyc;
    sbQ.push_back(r);
    r.startCyc = cyc + SWEEP_EDGES + 2;
    sbQ.push_back(r);
    waitDone(100);
    d1 = cyc;
    repeat (2) @(negedge clk);
    checkOutput("b2b_restart_busy", busy, 1);
    checkOutput("b2b_pass_cleared", pass, 0);
    checkOutput("b2b_cnt_cleared", misCnt, 0);
    start = 1'b0;
    waitDone(100);
    checkOutput("b2b_spacing", cyc - d1, SWEEP_EDGES + 2);
    repeat (3) @(negedge clk);

    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
